// File: rtl/fxp_alu_pipe.sv
// -----------------------------------------------------------------------------
// fxp_alu_pipe
//
// Three-stage pipelined saturating fixed-point ALU (two's complement, Q format)
// with a guarded MAC accumulator and valid/ready handshakes on both sides.
//
//   S1  : operand registers
//   S2  : full 2W-bit product, (W+1)-bit sum/difference, arithmetic shift
//   OUT : rounding, saturation, accumulator update, result registers
//
// Modes (in_mode_i):
//   0 ADD | 1 SUB | 2 MUL | 3 MAC | 4 ACC_CLR | 5 ACC_RD | 6 SHRA | 7 NOP
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_n_i      synchronous active-low reset
//   in_valid_i   operation presented
//   in_ready_o   operation accepted this cycle when high (equals advance)
//   in_mode_i    operation select
//   in_a_i       operand A (Q format)
//   in_b_i       operand B (Q format)
//   in_shift_i   SHRA shift amount
//   in_tag_i     opaque tag carried with the operation
//   out_valid_o  result valid
//   out_ready_i  consumer accepts the result
//   out_data_o   result
//   out_ovf_o    result was saturated
//   out_tag_o    tag of this result
// -----------------------------------------------------------------------------
module fxp_alu_pipe #(
    parameter int W     = 16,
    parameter int Q     = 15,
    parameter int GUARD = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           in_mode_i,
    input  logic [W-1:0]         in_a_i,
    input  logic [W-1:0]         in_b_i,
    input  logic [$clog2(W)-1:0] in_shift_i,
    input  logic [TAG_W-1:0]     in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [W-1:0]         out_data_o,
    output logic                 out_ovf_o,
    output logic [TAG_W-1:0]     out_tag_o
);

    localparam int ACC_W = W + GUARD;
    localparam int SH_W  = $clog2(W);
    localparam int PW    = 2 * W;
    // Working width for acc + R: one bit above the wider of the two operands,
    // so the addition itself can never wrap.
    localparam int XW    = ((PW + 1) > ACC_W ? (PW + 1) : ACC_W) + 1;

    localparam logic [2:0] MODE_ADD  = 3'd0;
    localparam logic [2:0] MODE_SUB  = 3'd1;
    localparam logic [2:0] MODE_MUL  = 3'd2;
    localparam logic [2:0] MODE_MAC  = 3'd3;
    localparam logic [2:0] MODE_CLR  = 3'd4;
    localparam logic [2:0] MODE_RD   = 3'd5;
    localparam logic [2:0] MODE_SHRA = 3'd6;
    localparam logic [2:0] MODE_NOP  = 3'd7;

    localparam logic [W-1:0]     MIN_W   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     MAX_W   = {1'b0, {(W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_ACC = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] MAX_ACC = {1'b0, {(ACC_W-1){1'b1}}};
    // Half an LSB of the result, added before the shift for round-half-up.
    localparam logic [PW:0]      RND     = {{PW{1'b0}}, 1'b1} << (Q - 1);

    // Saturate an accumulator-width value to W bits; MSB of the return is ovf.
    function automatic logic [W:0] sat_acc_w(input logic [ACC_W-1:0] v);
        logic clip;
        clip = (v[ACC_W-1:W-1] != {(GUARD+1){v[W-1]}});
        if (clip) begin
            return {1'b1, (v[ACC_W-1] ? MIN_W : MAX_W)};
        end
        return {1'b0, v[W-1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Handshake: the whole pipe moves only when the output slot is free
    // or being drained this cycle.
    // ------------------------------------------------------------------
    logic advance;
    logic out_valid_q;

    assign advance    = !(out_valid_q && !out_ready_i);
    assign in_ready_o = advance;

    // ------------------------------------------------------------------
    // S1: operand registers
    // ------------------------------------------------------------------
    logic             s1_valid_q;
    logic [2:0]       s1_mode_q;
    logic [W-1:0]     s1_a_q;
    logic [W-1:0]     s1_b_q;
    logic [SH_W-1:0]  s1_shift_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_NOP;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_shift_q <= '0;
            s1_tag_q   <= '0;
        end else if (advance) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_mode_q  <= in_mode_i;
                s1_a_q     <= in_a_i;
                s1_b_q     <= in_b_i;
                s1_shift_q <= in_shift_i;
                s1_tag_q   <= in_tag_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: exact arithmetic
    // ------------------------------------------------------------------
    logic [W:0]    s2_sum_d;
    logic [PW-1:0] s2_prod_d;
    logic [W-1:0]  s2_shr_d;
    logic [W:0]    a_ext;
    logic [W:0]    b_ext;

    assign a_ext     = {s1_a_q[W-1], s1_a_q};
    assign b_ext     = {s1_b_q[W-1], s1_b_q};
    assign s2_sum_d  = (s1_mode_q == MODE_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    assign s2_prod_d = $signed(s1_a_q) * $signed(s1_b_q);
    assign s2_shr_d  = $signed(s1_a_q) >>> s1_shift_q;

    logic             s2_valid_q;
    logic [2:0]       s2_mode_q;
    logic [W:0]       s2_sum_q;
    logic [PW-1:0]    s2_prod_q;
    logic [W-1:0]     s2_shr_q;
    logic [TAG_W-1:0] s2_tag_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= MODE_NOP;
            s2_sum_q   <= '0;
            s2_prod_q  <= '0;
            s2_shr_q   <= '0;
            s2_tag_q   <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_q <= s1_mode_q;
                s2_sum_q  <= s2_sum_d;
                s2_prod_q <= s2_prod_d;
                s2_shr_q  <= s2_shr_d;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // OUT: rounding, saturation, accumulation
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // ADD/SUB: the (W+1)-bit result overflows W bits when its top two differ.
    logic         sum_ovf;
    logic [W-1:0] sum_sat;
    assign sum_ovf = (s2_sum_q[W] != s2_sum_q[W-1]);
    assign sum_sat = sum_ovf ? (s2_sum_q[W] ? MIN_W : MAX_W) : s2_sum_q[W-1:0];

    // MUL: one extra bit of headroom keeps the rounding add from wrapping.
    logic [PW:0]  p_rnd;
    logic [PW:0]  mul_r;
    logic         mul_ovf;
    logic [W-1:0] mul_sat;
    assign p_rnd   = {s2_prod_q[PW-1], s2_prod_q} + RND;
    assign mul_r   = $signed(p_rnd) >>> Q;
    assign mul_ovf = (mul_r[PW:W-1] != {(PW-W+2){mul_r[W-1]}});
    assign mul_sat = mul_ovf ? (mul_r[PW] ? MIN_W : MAX_W) : mul_r[W-1:0];

    // MAC: unsaturated R is added to the accumulator, then clipped to ACC_W.
    logic [XW-1:0]    acc_ext;
    logic [XW-1:0]    mul_ext;
    logic [XW-1:0]    mac_sum;
    logic             mac_ovf;
    logic [ACC_W-1:0] mac_acc;
    assign acc_ext = {{(XW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign mul_ext = {{(XW-PW-1){mul_r[PW]}}, mul_r};
    assign mac_sum = acc_ext + mul_ext;
    assign mac_ovf = (mac_sum[XW-1:ACC_W-1] != {(XW-ACC_W+1){mac_sum[ACC_W-1]}});
    assign mac_acc = mac_ovf ? (mac_sum[XW-1] ? MIN_ACC : MAX_ACC) : mac_sum[ACC_W-1:0];

    logic [W-1:0] res_data_d;
    logic         res_ovf_d;
    logic [W:0]   acc_sat;

    always_comb begin
        res_data_d = '0;
        res_ovf_d  = 1'b0;
        acc_d      = acc_q;
        acc_sat    = '0;
        case (s2_mode_q)
            MODE_ADD, MODE_SUB: begin
                res_data_d = sum_sat;
                res_ovf_d  = sum_ovf;
            end
            MODE_MUL: begin
                res_data_d = mul_sat;
                res_ovf_d  = mul_ovf;
            end
            MODE_MAC: begin
                acc_d      = mac_acc;
                acc_sat    = sat_acc_w(mac_acc);
                res_data_d = acc_sat[W-1:0];
                res_ovf_d  = acc_sat[W] | mac_ovf;
            end
            MODE_CLR: begin
                acc_d = '0;
            end
            MODE_RD: begin
                acc_sat    = sat_acc_w(acc_q);
                res_data_d = acc_sat[W-1:0];
                res_ovf_d  = acc_sat[W];
            end
            MODE_SHRA: begin
                res_data_d = s2_shr_q;
            end
            default: begin
            end
        endcase
    end

    logic [W-1:0]     out_data_q;
    logic             out_ovf_q;
    logic [TAG_W-1:0] out_tag_q;

    // The accumulator commits in the same enable as the result register,
    // so accumulator operations take effect strictly in issue order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_tag_q   <= '0;
            acc_q       <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q <= res_data_d;
                out_ovf_q  <= res_ovf_d;
                out_tag_q  <= s2_tag_q;
                acc_q      <= acc_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ovf_o   = out_ovf_q;
    assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_fxp_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_fxp_alu_pipe
//
// Directed bench for fxp_alu_pipe. A behavioural integer model computes the
// expected result of every accepted operation and pushes it to a queue; a
// monitor pops and compares whenever the DUT hands a result to the consumer.
// -----------------------------------------------------------------------------
module tb_fxp_alu_pipe;

    localparam int W     = 16;
    localparam int Q     = 15;
    localparam int GUARD = 4;
    localparam int TAG_W = 4;
    localparam int ACC_W = W + GUARD;
    localparam int SH_W  = 4;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, MAC = 3'd3,
                           CLR = 3'd4, RD  = 3'd5, SHR = 3'd6, NOP = 3'd7;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_mode;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [SH_W-1:0]  in_shift;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    fxp_alu_pipe #(.W(W), .Q(Q), .GUARD(GUARD), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_mode_i   (in_mode),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_shift_i  (in_shift),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ovf_o   (out_ovf),
        .out_tag_o   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     d;
        logic             o;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t   sb_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    longint m_acc    = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic longint sat_m(input longint v, input int n, output bit o);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (n - 1)) - 1;
        mn = -(longint'(1) <<< (n - 1));
        o = 1'b0;
        if (v > mx) begin
            o = 1'b1;
            return mx;
        end
        if (v < mn) begin
            o = 1'b1;
            return mn;
        end
        return v;
    endfunction

    function automatic exp_t model(input logic [2:0] m, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [SH_W-1:0] sh,
                                   input logic [TAG_W-1:0] t);
        longint sa;
        longint sb;
        longint r;
        longint v;
        bit     o1;
        bit     o2;
        exp_t   e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o1 = 1'b0;
        o2 = 1'b0;
        v  = 0;
        r  = (sa * sb + (longint'(1) <<< (Q - 1))) >>> Q;
        case (m)
            ADD: v = sat_m(sa + sb, W, o1);
            SUB: v = sat_m(sa - sb, W, o1);
            MUL: v = sat_m(r, W, o1);
            MAC: begin
                m_acc = sat_m(m_acc + r, ACC_W, o1);
                v     = sat_m(m_acc, W, o2);
            end
            CLR: m_acc = 0;
            RD:  v = sat_m(m_acc, W, o1);
            SHR: v = sa >>> sh;
            default: v = 0;
        endcase
        e.d = v[W-1:0];
        e.o = o1 | o2;
        e.t = t;
        return e;
    endfunction

    // Present one operation; returns one tick after the edge that accepted it.
    task automatic send(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SH_W-1:0] sh, input logic [TAG_W-1:0] t);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        in_shift = sh;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("send_accept_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            sb_q.push_back(model(m, a, b, sh, t));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_remaining", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard compare, output stability under stall, ready rule.
    logic             prev_stall = 1'b0;
    logic [W-1:0]     prev_d;
    logic             prev_o;
    logic [TAG_W-1:0] prev_t;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {16'd0, out_data}, {16'd0, prev_d});
                check("stall_tag", {28'd0, out_tag}, {28'd0, prev_t});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_data", {16'd0, out_data}, {16'd0, e.d});
                    check("out_ovf", {31'd0, out_ovf}, {31'd0, e.o});
                    check("out_tag", {28'd0, out_tag}, {28'd0, e.t});
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_d     <= out_data;
            prev_o     <= out_ovf;
            prev_t     <= out_tag;
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = NOP;
        in_a      = '0;
        in_b      = '0;
        in_shift  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 1. ADD/SUB saturation, plus latency of the first result
        send(ADD, 16'h4000, 16'h4000, 4'd0, 4'd3);
        @(negedge clk);
        check("latency_edge0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_edge1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_edge2", {31'd0, out_valid}, 32'd1);
        check("add_sat_data", {16'd0, out_data}, 32'h7FFF);
        @(posedge clk);
        #1;
        send(SUB, 16'h8000, 16'h0001, 4'd0, 4'd4);
        send(ADD, 16'h1000, 16'hF000, 4'd0, 4'd5);
        drain();

        // 2. MUL rounding and saturation
        send(MUL, 16'h4000, 16'h4000, 4'd0, 4'd1);
        send(MUL, 16'h8000, 16'h8000, 4'd0, 4'd2);
        send(MUL, 16'h0001, 16'h4000, 4'd0, 4'd3);
        drain();

        // 3. MAC with guard bits
        send(CLR, 16'h0000, 16'h0000, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            send(MAC, 16'h4000, 16'h4000, 4'd0, 4'(i + 1));
        end
        send(RD, 16'h0000, 16'h0000, 4'd0, 4'd6);
        send(MAC, 16'hC000, 16'h4000, 4'd0, 4'd7);
        drain();

        // 4. Backpressure over a mixed stream
        fork
            begin
                send(CLR, 16'h0000, 16'h0000, 4'd0, 4'd0);
                send(MAC, 16'h2000, 16'h4000, 4'd0, 4'd1);
                send(ADD, 16'h1234, 16'h0111, 4'd0, 4'd2);
                send(MAC, 16'hE000, 16'h2000, 4'd0, 4'd3);
                send(SUB, 16'h0100, 16'h0300, 4'd0, 4'd4);
                send(RD, 16'h0000, 16'h0000, 4'd0, 4'd5);
                send(SHR, 16'hA000, 16'h0000, 4'd3, 4'd6);
                send(MUL, 16'hC000, 16'hC000, 4'd0, 4'd7);
                send(NOP, 16'h5555, 16'h5555, 4'd0, 4'd8);
                send(MAC, 16'h7FFF, 16'h7FFF, 4'd0, 4'd9);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(RD, 16'h0000, 16'h0000, 4'd0, 4'd10);
        drain();

        // 5. Reset with operations in flight
        send(CLR, 16'h0000, 16'h0000, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            send(MAC, 16'h4000, 16'h4000, 4'd0, 4'(i + 1));
        end
        drain();
        out_ready = 1'b0;
        send(MAC, 16'h4000, 16'h4000, 4'd0, 4'd11);
        send(ADD, 16'h0001, 16'h0002, 4'd0, 4'd12);
        send(RD, 16'h0000, 16'h0000, 4'd0, 4'd13);
        @(negedge clk);
        check("inflight_held", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        m_acc = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(RD, 16'h0000, 16'h0000, 4'd0, 4'd14);
        drain();

        // 6. Arithmetic shift right
        send(SHR, 16'h8000, 16'h0000, 4'd4, 4'd1);
        send(SHR, 16'h7FFF, 16'h0000, 4'd15, 4'd2);
        send(SHR, 16'hFFFF, 16'h0000, 4'd0, 4'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
